// File: rtl/voice_scheduler.sv
// voice_scheduler: per-sample sequencer for the eight PWM voices.
// Each tick walks voices 0..7, fetching one wavetable sample per enabled voice.
module voice_scheduler #(
    parameter int NUM_VOICES = 8,
    parameter int DUTY_W     = 8,
    parameter int PHASE_W    = 16,
    parameter int ADDR_W     = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic                         cfg_we,
    input  logic [3:0]                   cfg_addr,
    input  logic [15:0]                  cfg_wdata,
    input  logic                         host_mem_en,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic [15:0]                  mem_rdata,
    output logic [NUM_VOICES*DUTY_W-1:0] duty_flat,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam logic [3:0] CFG_MASK = 4'd8;
    localparam logic [3:0] CFG_CLR  = 4'd9;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [VW-1:0]           v_q, v_d;
    logic [PHASE_W-1:0]      phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]      phase_d [NUM_VOICES];
    logic [PHASE_W-1:0]      inc_q   [NUM_VOICES];
    logic [PHASE_W-1:0]      inc_d   [NUM_VOICES];
    logic [DUTY_W-1:0]       duty_q  [NUM_VOICES];
    logic [DUTY_W-1:0]       duty_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0]   mask_q, mask_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overrun_q, overrun_d;

    logic en_v;
    logic last;
    logic slot_done;
    logic unused_rdata;

    assign en_v      = mask_q[v_q];
    assign last      = (v_q == VW'(NUM_VOICES - 1));
    assign slot_done = ((state_q == ISSUE) && !en_v) ||
                       ((state_q == WAIT) && mem_ack);
    assign unused_rdata = ^mem_rdata[15-DUTY_W:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            v_q          <= '0;
            phase_q      <= '{default: '0};
            inc_q        <= '{default: '0};
            duty_q       <= '{default: '0};
            mask_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            phase_q      <= phase_d;
            inc_q        <= inc_d;
            duty_q       <= duty_d;
            mask_q       <= mask_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = ISSUE;
                    v_d     = '0;
                end
            end
            ISSUE: begin
                if (en_v && !host_mem_en) state_d = WAIT;
            end
            WAIT: ;
            default: state_d = IDLE;
        endcase
        if (slot_done) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                state_d = ISSUE;
                v_d     = v_q + 1'b1;
            end
        end
    end

    always_comb begin
        phase_d      = phase_q;
        inc_d        = inc_q;
        duty_d       = duty_q;
        mask_d       = mask_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        frame_done_d = slot_done && last;
        overrun_d    = overrun_q;
        if (cfg_we) begin
            if (cfg_addr < 4'(NUM_VOICES))
                inc_d[cfg_addr[VW-1:0]] = cfg_wdata[PHASE_W-1:0];
            else if (cfg_addr == CFG_MASK)
                mask_d = cfg_wdata[NUM_VOICES-1:0];
            else if (cfg_addr == CFG_CLR)
                overrun_d = 1'b0;
        end
        // a dropped tick outranks a same-cycle clear
        if (sample_tick && state_q != IDLE) overrun_d = 1'b1;
        unique case (state_q)
            ISSUE: begin
                if (!en_v) begin
                    duty_d[v_q]  = '0;
                    phase_d[v_q] = '0;
                end else if (!host_mem_en) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = phase_q[v_q][PHASE_W-1 -: ADDR_W];
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    duty_d[v_q]  = mem_rdata[15 -: DUTY_W];
                    phase_d[v_q] = phase_q[v_q] + inc_q[v_q];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        duty_flat = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            duty_flat[i*DUTY_W +: DUTY_W] = duty_q[i];
    end

    assign busy       = (state_q != IDLE);
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
